// File: rtl/mc_ctl_fsm_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctl_fsm_pkg
// Shared definitions for the multicycle RV32I control FSM:
//   - ctl_state_t   : FSM state encoding
//   - TYPE_*        : RV32I opcodes recognised by the decoder
//   - ALU_*         : alucontrol encodings driven to the ALU
//   - aluop_t       : internal ALU operation class handed to alu_decoder
//   - RES_/SRCA_/SRCB_/IMM_* : datapath mux select encodings
//   - cnt_width()   : width of the memory wait counter for a given timeout
// ----------------------------------------------------------------------------
package mc_ctl_fsm_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXEC_R,
      EXEC_I,
      ALUWB,
      BEQ,
      JAL,
      TRAP
   } ctl_state_t;

   localparam logic [6:0] TYPE_R      = 7'b0110011;
   localparam logic [6:0] TYPE_I_ALU  = 7'b0010011;
   localparam logic [6:0] TYPE_I_LOAD = 7'b0000011;
   localparam logic [6:0] TYPE_S      = 7'b0100011;
   localparam logic [6:0] TYPE_B      = 7'b1100011;
   localparam logic [6:0] TYPE_J      = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // A timeout of 0 disables the abort but still needs a 1-bit counter.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mc_ctl_fsm_if.sv
// ----------------------------------------------------------------------------
// mc_ctl_fsm_if
// Bundle between the control FSM and the multicycle datapath.
//   Datapath -> FSM : op, funct3, funct7_5, zero, mem_ready
//   FSM -> datapath : pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc,
//                     alusrca, alusrcb, immsrc, alucontrol, instr_done,
//                     mem_timeout
// Modports: master = control FSM, slave = datapath.
// ----------------------------------------------------------------------------
interface mc_ctl_fsm_if;

   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       zero;
   logic       mem_ready;

   logic       pcwrite;
   logic       adrsrc;
   logic       irwrite;
   logic       memwrite;
   logic       regwrite;
   logic [1:0] resultsrc;
   logic [1:0] alusrca;
   logic [1:0] alusrcb;
   logic [1:0] immsrc;
   logic [2:0] alucontrol;
   logic       instr_done;
   logic       mem_timeout;

   modport master (
      input  op, funct3, funct7_5, zero, mem_ready,
      output pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc,
             alusrca, alusrcb, immsrc, alucontrol, instr_done, mem_timeout
   );

   modport slave (
      output op, funct3, funct7_5, zero, mem_ready,
      input  pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc,
             alusrca, alusrcb, immsrc, alucontrol, instr_done, mem_timeout
   );

endinterface

// File: rtl/mc_ctl_fsm_alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Maps the FSM's ALU operation class plus instruction fields to alucontrol.
//   aluop      in  2  00 add, 01 sub, 10 decode from funct3
//   funct3     in  3  IR funct3
//   op_5       in  1  IR opcode bit 5 (set for R-type, clear for I-ALU)
//   funct7_5   in  1  IR bit 30
//   alucontrol out 3  ALU_* encoding
// ----------------------------------------------------------------------------
module alu_decoder
   import mc_ctl_fsm_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       op_5,
   input  logic       funct7_5,
   output logic [2:0] alucontrol
);

   always_comb begin
      // NOTE: default assigned before the case so every path drives the
      // output and no latch is inferred.
      alucontrol = ALU_ADD;
      case (aluop)
         2'b00: alucontrol = ALU_ADD;
         2'b01: alucontrol = ALU_SUB;
         2'b10: begin
            case (funct3)
               // addi has no sub form: bit 30 only selects SUB for R-type.
               3'b000:  alucontrol = (op_5 & funct7_5) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol = ALU_SLT;
               3'b110:  alucontrol = ALU_OR;
               3'b111:  alucontrol = ALU_AND;
               default: alucontrol = 3'b000;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_ctl_fsm.sv
// ----------------------------------------------------------------------------
// mc_ctl_fsm
// Multicycle RV32I control FSM. Steps the shared ALU / register file /
// unified memory datapath through fetch, decode, execute and writeback one
// instruction at a time, stalling on mem_ready. All outputs are combinational
// from the state register and current inputs.
//
// Parameters
//   MEM_TIMEOUT  consecutive mem_ready=0 wait cycles before abort (0 = never)
// Ports
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   bus            --   mc_ctl_fsm_if.master (IR fields, zero, mem_ready in;
//                       mux selects, enables, alucontrol, pulses out)
//   illegal_instr  out  only with MC_CTL_ILLEGAL_TRAP_EN defined: high while
//                       parked in TRAP after an unknown opcode
// Build option
//   MC_CTL_ILLEGAL_TRAP_EN  undefined: unknown opcodes retire as a NOP.
//                           defined: unknown opcodes lock into TRAP until rst.
// ----------------------------------------------------------------------------
module mc_ctl_fsm
   import mc_ctl_fsm_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst,
   mc_ctl_fsm_if.master bus
`ifdef MC_CTL_ILLEGAL_TRAP_EN
   ,
   output logic         illegal_instr
`endif
);

   localparam int            CW       = cnt_width(MEM_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   ctl_state_t    state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   aluop_t        aluop;
   logic          pcupdate;
   logic          branch;
   logic          wait_state;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed in the previous combinational settle, independent of order.
      if (rst) begin
         state <= FETCH;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next       = state;
      cnt_next         = '0;
      aluop            = ALUOP_ADD;
      pcupdate         = 1'b0;
      branch           = 1'b0;
      wait_state       = 1'b0;
      bus.adrsrc       = 1'b0;
      bus.irwrite      = 1'b0;
      bus.memwrite     = 1'b0;
      bus.regwrite     = 1'b0;
      bus.resultsrc    = RES_ALUOUT;
      bus.alusrca      = SRCA_PC;
      bus.alusrcb      = SRCB_RS2;
      bus.instr_done   = 1'b0;
      bus.mem_timeout  = 1'b0;

      case (state)
         FETCH: begin
            wait_state    = 1'b1;
            bus.alusrcb   = SRCB_FOUR;
            bus.resultsrc = RES_ALURESULT;
            bus.irwrite   = bus.mem_ready;
            pcupdate      = bus.mem_ready;
            if (bus.mem_ready) state_next = DECODE;
         end
         DECODE: begin
            // Branch target PC+imm is computed here and parked in ALUOut.
            bus.alusrca = SRCA_OLDPC;
            bus.alusrcb = SRCB_IMM;
            case (bus.op)
               TYPE_I_LOAD, TYPE_S: state_next = MEMADR;
               TYPE_R:              state_next = EXEC_R;
               TYPE_I_ALU:          state_next = EXEC_I;
               TYPE_B:              state_next = BEQ;
               TYPE_J:              state_next = JAL;
               default: begin
`ifdef MC_CTL_ILLEGAL_TRAP_EN
                  state_next = TRAP;
`else
                  state_next     = FETCH;
                  bus.instr_done = 1'b1;
`endif
               end
            endcase
         end
         MEMADR: begin
            bus.alusrca = SRCA_RS1;
            bus.alusrcb = SRCB_IMM;
            state_next  = (bus.op == TYPE_I_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            wait_state = 1'b1;
            bus.adrsrc = 1'b1;
            if (bus.mem_ready) state_next = MEMWB;
         end
         MEMWB: begin
            bus.resultsrc  = RES_MEMDATA;
            bus.regwrite   = 1'b1;
            bus.instr_done = 1'b1;
            state_next     = FETCH;
         end
         MEMWRITE: begin
            wait_state   = 1'b1;
            bus.adrsrc   = 1'b1;
            bus.memwrite = 1'b1;
            if (bus.mem_ready) begin
               bus.instr_done = 1'b1;
               state_next     = FETCH;
            end
         end
         EXEC_R: begin
            bus.alusrca = SRCA_RS1;
            bus.alusrcb = SRCB_RS2;
            aluop       = ALUOP_FUNCT;
            state_next  = ALUWB;
         end
         EXEC_I: begin
            bus.alusrca = SRCA_RS1;
            bus.alusrcb = SRCB_IMM;
            aluop       = ALUOP_FUNCT;
            state_next  = ALUWB;
         end
         ALUWB: begin
            bus.regwrite   = 1'b1;
            bus.instr_done = 1'b1;
            state_next     = FETCH;
         end
         BEQ: begin
            bus.alusrca    = SRCA_RS1;
            bus.alusrcb    = SRCB_RS2;
            aluop          = ALUOP_SUB;
            branch         = 1'b1;
            bus.instr_done = 1'b1;
            state_next     = FETCH;
         end
         JAL: begin
            // ALU computes PC+4 for rd while ALUOut already holds the target.
            bus.alusrca = SRCA_OLDPC;
            bus.alusrcb = SRCB_FOUR;
            pcupdate    = 1'b1;
            state_next  = ALUWB;
         end
         TRAP: state_next = TRAP;
         default: state_next = FETCH;
      endcase

      // Wait-state counter: runs while stalled, cleared everywhere else so it
      // starts from zero on every entry. mem_ready takes priority over abort.
      if (wait_state && !bus.mem_ready) begin
         if ((MEM_TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            bus.mem_timeout = 1'b1;
            state_next      = FETCH;
            cnt_next        = '0;
         end else begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
         end
      end

      // Reset abandons the instruction: nothing may commit in this cycle.
      if (rst) begin
         state_next      = FETCH;
         cnt_next        = '0;
         pcupdate        = 1'b0;
         branch          = 1'b0;
         bus.irwrite     = 1'b0;
         bus.memwrite    = 1'b0;
         bus.regwrite    = 1'b0;
         bus.instr_done  = 1'b0;
         bus.mem_timeout = 1'b0;
      end
   end

   assign bus.pcwrite = pcupdate | (branch & bus.zero);

   // Immediate format depends only on the opcode, not on the state.
   always_comb begin
      case (bus.op)
         TYPE_S:  bus.immsrc = IMM_S;
         TYPE_B:  bus.immsrc = IMM_B;
         TYPE_J:  bus.immsrc = IMM_J;
         default: bus.immsrc = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop      (aluop),
      .funct3     (bus.funct3),
      .op_5       (bus.op[5]),
      .funct7_5   (bus.funct7_5),
      .alucontrol (bus.alucontrol)
   );

`ifdef MC_CTL_ILLEGAL_TRAP_EN
   assign illegal_instr = (state == TRAP);
`endif

endmodule
